vga_flag_sequencer: RTL and testbench

//   Picks which pride flag the VGA pattern generator draws, and when it changes.

---
 rtl/vga_flag_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_vga_flag_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_flag_sequencer.sv
// vga_flag_sequencer
// Chooses the flag index shown by the VGA pattern generator. The index advances
// automatically after a programmable number of frames, or when the next/prev
// buttons are pressed. Each change can run a frame-paced fade-out, swap and
// fade-in, so the pixel datapath only has to scale its RGB output by fade_level.
module vga_flag_sequencer #(
    parameter int NUM_FLAGS = 16,
    parameter int FLAG_W    = 4,
    parameter int DWELL_W   = 8,
    parameter int FADE_MAX  = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic                              btn_next,
    input  logic                              btn_prev,
    input  logic                              auto_en,
    input  logic                              fade_en,
    input  logic [DWELL_W-1:0]                dwell_frames,
    output logic [FLAG_W-1:0]                 flag_sel,
    output logic [$clog2(FADE_MAX+1)-1:0]     fade_level,
    output logic                              flag_changed,
    output logic                              busy
);

    localparam int FW = $clog2(FADE_MAX + 1);

    localparam logic [1:0] SHOW     = 2'd0;
    localparam logic [1:0] FADE_OUT = 2'd1;
    localparam logic [1:0] SWAP     = 2'd2;
    localparam logic [1:0] FADE_IN  = 2'd3;

    localparam logic [FW-1:0]     FADE_FULL = FW'(FADE_MAX);
    localparam logic [FLAG_W-1:0] FLAG_LAST = FLAG_W'(NUM_FLAGS - 1);

    // Steps the flag index one place forward (dir=1) or back (dir=0), wrapping
    // at both ends of the flag range rather than at the counter width.
    function automatic logic [FLAG_W-1:0] step_flag(input logic [FLAG_W-1:0] cur,
                                                    input logic              dir);
        logic [FLAG_W-1:0] res;
        if (dir == 1'b1) begin
            if (cur == FLAG_LAST) begin
                res = {FLAG_W{1'b0}};
            end else begin
                res = cur + FLAG_W'(1);
            end
        end else begin
            if (cur == {FLAG_W{1'b0}}) begin
                res = FLAG_LAST;
            end else begin
                res = cur - FLAG_W'(1);
            end
        end
        return res;
    endfunction

    logic [1:0]         state_r;
    logic [FLAG_W-1:0]  flag_sel_r;
    logic [FW-1:0]      fade_level_r;
    logic               flag_changed_r;
    logic               busy_r;
    logic               dir_r;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic               btn_next_q_r;
    logic               btn_prev_q_r;

    logic [1:0]         state_nxt_s;
    logic [FLAG_W-1:0]  flag_nxt_s;
    logic [FW-1:0]      level_nxt_s;
    logic               changed_nxt_s;
    logic               dir_nxt_s;
    logic [DWELL_W-1:0] cnt_nxt_s;
    logic [DWELL_W:0]   cnt_inc_s;
    logic               auto_req_s;
    logic               nxt_e_s;
    logic               prv_e_s;
    logic               man_req_s;

    // Rising-edge detection; simultaneous next and prev cancel each other, and
    // edges outside SHOW are simply dropped.
    assign nxt_e_s   = btn_next & ~btn_next_q_r;
    assign prv_e_s   = btn_prev & ~btn_prev_q_r;
    assign man_req_s = (state_r == SHOW) && ((nxt_e_s ^ prv_e_s) == 1'b1);
    assign cnt_inc_s = {1'b0, dwell_cnt_r} + {{DWELL_W{1'b0}}, 1'b1};

    // Dwell counter: counts frames while showing a flag and raises the auto request
    // on the frame that reaches dwell_frames; a counter left above a lowered
    // dwell_frames clears instead of wrapping.
    always_comb begin
        auto_req_s = 1'b0;
        cnt_nxt_s  = dwell_cnt_r;
        if (auto_en == 1'b0) begin
            cnt_nxt_s = {DWELL_W{1'b0}};
        end else if (state_r != SHOW) begin
            cnt_nxt_s = dwell_cnt_r;
        end else if (dwell_frames == {DWELL_W{1'b0}}) begin
            cnt_nxt_s = {DWELL_W{1'b0}};
        end else if (frame_start == 1'b1) begin
            if (cnt_inc_s == {1'b0, dwell_frames}) begin
                auto_req_s = 1'b1;
                cnt_nxt_s  = {DWELL_W{1'b0}};
            end else if (cnt_inc_s > {1'b0, dwell_frames}) begin
                cnt_nxt_s = {DWELL_W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_inc_s[DWELL_W-1:0];
            end
        end else begin
            cnt_nxt_s = dwell_cnt_r;
        end
        if (man_req_s == 1'b1) begin
            cnt_nxt_s = {DWELL_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_nxt_s;
        end
    end

    // Transition sequencer: the flag index changes on entry to SWAP so that
    // flag_changed and the new flag_sel appear in the same cycle.
    always_comb begin
        state_nxt_s   = state_r;
        flag_nxt_s    = flag_sel_r;
        level_nxt_s   = fade_level_r;
        changed_nxt_s = 1'b0;
        dir_nxt_s     = dir_r;
        case (state_r)
            SHOW: begin
                if ((man_req_s | auto_req_s) == 1'b1) begin
                    // A manual press overrides the direction of a coincident auto request.
                    dir_nxt_s = man_req_s ? nxt_e_s : 1'b1;
                    if (fade_en == 1'b1) begin
                        state_nxt_s = FADE_OUT;
                    end else begin
                        state_nxt_s   = SWAP;
                        flag_nxt_s    = step_flag(flag_sel_r, dir_nxt_s);
                        changed_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = SHOW;
                end
            end
            FADE_OUT: begin
                if (frame_start == 1'b1) begin
                    if (fade_level_r == {FW{1'b0}}) begin
                        state_nxt_s   = SWAP;
                        flag_nxt_s    = step_flag(flag_sel_r, dir_r);
                        changed_nxt_s = 1'b1;
                    end else begin
                        level_nxt_s = fade_level_r - FW'(1);
                    end
                end else begin
                    state_nxt_s = FADE_OUT;
                end
            end
            SWAP: begin
                // An instant swap never dimmed, so it returns straight to SHOW.
                if (fade_level_r != FADE_FULL) begin
                    state_nxt_s = FADE_IN;
                end else begin
                    state_nxt_s = SHOW;
                end
            end
            FADE_IN: begin
                if (frame_start == 1'b1) begin
                    if (fade_level_r == FADE_FULL) begin
                        state_nxt_s = SHOW;
                    end else begin
                        level_nxt_s = fade_level_r + FW'(1);
                    end
                end else begin
                    state_nxt_s = FADE_IN;
                end
            end
            default: begin
                state_nxt_s = SHOW;
                level_nxt_s = FADE_FULL;
            end
        endcase
    end

    // State and output registers; busy is registered from the next state so it
    // tracks state != SHOW without a combinational output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= SHOW;
            flag_sel_r     <= {FLAG_W{1'b0}};
            fade_level_r   <= FADE_FULL;
            flag_changed_r <= 1'b0;
            busy_r         <= 1'b0;
            dir_r          <= 1'b1;
            dwell_cnt_r    <= {DWELL_W{1'b0}};
            btn_next_q_r   <= 1'b0;
            btn_prev_q_r   <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            flag_sel_r     <= flag_nxt_s;
            fade_level_r   <= level_nxt_s;
            flag_changed_r <= changed_nxt_s;
            busy_r         <= (state_nxt_s != SHOW);
            dir_r          <= dir_nxt_s;
            dwell_cnt_r    <= cnt_nxt_s;
            btn_next_q_r   <= btn_next;
            btn_prev_q_r   <= btn_prev;
        end
    end

    assign flag_sel     = flag_sel_r;
    assign fade_level   = fade_level_r;
    assign flag_changed = flag_changed_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vga_flag_sequencer.sv
// Directed testbench for vga_flag_sequencer: reset, instant and faded changes,
// wrap-around, auto-advance, input collisions and disabled auto mode.
module tb_vga_flag_sequencer;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic       fade_en;
    logic [7:0] dwell_frames;
    logic [3:0] flag_sel;
    logic [2:0] fade_level;
    logic       flag_changed;
    logic       busy;

    int total;
    int bad;
    logic [3:0] exp_flag;

    vga_flag_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .auto_en      (auto_en),
        .fade_en      (fade_en),
        .dwell_frames (dwell_frames),
        .flag_sel     (flag_sel),
        .fade_level   (fade_level),
        .flag_changed (flag_changed),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic press(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL reset_flag got=%0d want=0", flag_sel); end
        total++; if (fade_level !== 3'd7) begin bad++; $display("FAIL reset_level got=%0d want=7", fade_level); end
        total++; if (flag_changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%0b want=0", flag_changed); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_manual_instant();
        fade_en = 1'b0;
        btn_next = 1'b1;
        tick();
        total++; if (flag_sel !== 4'd1) begin bad++; $display("FAIL t2_flag got=%0d want=1", flag_sel); end
        total++; if (flag_changed !== 1'b1) begin bad++; $display("FAIL t2_changed got=%0b want=1", flag_changed); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t2_busy got=%0b want=1", busy); end
        tick();
        total++; if (flag_changed !== 1'b0) begin bad++; $display("FAIL t2_changed_end got=%0b want=0", flag_changed); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_busy_end got=%0b want=0", busy); end
        total++; if (flag_sel !== 4'd1) begin bad++; $display("FAIL t2_flag_hold got=%0d want=1", flag_sel); end
        btn_next = 1'b0;
        tick();
        exp_flag = 4'd1;
    endtask

    task automatic test_wrap();
        fade_en = 1'b0;
        press(1'b0, 1'b1);
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL t3_prev_to0 got=%0d want=0", flag_sel); end
        press(1'b0, 1'b1);
        total++; if (flag_sel !== 4'd15) begin bad++; $display("FAIL t3_prev_wrap got=%0d want=15", flag_sel); end
        press(1'b1, 1'b0);
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL t3_next_wrap got=%0d want=0", flag_sel); end
        for (int i = 0; i < 15; i++) begin
            press(1'b1, 1'b0);
        end
        total++; if (flag_sel !== 4'd15) begin bad++; $display("FAIL t3_16_next got=%0d want=15", flag_sel); end
        exp_flag = 4'd15;
    endtask

    task automatic test_auto_fade();
        fade_en = 1'b0;
        press(1'b1, 1'b0);
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL t4_setup got=%0d want=0", flag_sel); end
        fade_en = 1'b1;
        dwell_frames = 8'd3;
        auto_en = 1'b1;
        frame();
        frame();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_dwell_busy got=%0b want=0", busy); end
        frame();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_fire_busy got=%0b want=1", busy); end
        total++; if (fade_level !== 3'd7) begin bad++; $display("FAIL t4_fire_level got=%0d want=7", fade_level); end
        for (int k = 1; k <= 7; k++) begin
            frame();
            total++; if (fade_level !== 3'(7 - k)) begin bad++; $display("FAIL t4_out_level got=%0d want=%0d", fade_level, 7 - k); end
        end
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL t4_pre_swap_flag got=%0d want=0", flag_sel); end
        frame();
        total++; if (flag_sel !== 4'd1) begin bad++; $display("FAIL t4_swap_flag got=%0d want=1", flag_sel); end
        total++; if (flag_changed !== 1'b1) begin bad++; $display("FAIL t4_swap_changed got=%0b want=1", flag_changed); end
        tick();
        total++; if (flag_changed !== 1'b0) begin bad++; $display("FAIL t4_changed_end got=%0b want=0", flag_changed); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_in_busy got=%0b want=1", busy); end
        for (int k = 1; k <= 7; k++) begin
            frame();
            total++; if (fade_level !== 3'(k)) begin bad++; $display("FAIL t4_in_level got=%0d want=%0d", fade_level, k); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_in_busy_full got=%0b want=1", busy); end
        frame();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_show_busy got=%0b want=0", busy); end
        total++; if (fade_level !== 3'd7) begin bad++; $display("FAIL t4_show_level got=%0d want=7", fade_level); end
        auto_en = 1'b0;
        tick();
        exp_flag = 4'd1;
    endtask

    task automatic test_collisions();
        fade_en = 1'b0;
        btn_next = 1'b1;
        btn_prev = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_both_busy got=%0b want=0", busy); end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick();
        total++; if (flag_sel !== exp_flag) begin bad++; $display("FAIL t5_both_flag got=%0d want=%0d", flag_sel, exp_flag); end
        // Manual prev on the auto-fire frame: manual direction wins.
        auto_en = 1'b1;
        dwell_frames = 8'd2;
        frame();
        frame_start = 1'b1;
        btn_prev = 1'b1;
        tick();
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL t5_prev_auto_flag got=%0d want=0", flag_sel); end
        total++; if (flag_changed !== 1'b1) begin bad++; $display("FAIL t5_prev_auto_changed got=%0b want=1", flag_changed); end
        frame_start = 1'b0;
        btn_prev = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_prev_auto_busy got=%0b want=0", busy); end
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL t5_prev_auto_single got=%0d want=0", flag_sel); end
        // Manual next on the auto-fire frame: a single advance.
        frame();
        frame_start = 1'b1;
        btn_next = 1'b1;
        tick();
        frame_start = 1'b0;
        btn_next = 1'b0;
        tick();
        tick();
        total++; if (flag_sel !== 4'd1) begin bad++; $display("FAIL t5_next_auto_flag got=%0d want=1", flag_sel); end
        auto_en = 1'b0;
        tick();
        // Prev during FADE_IN is dropped.
        fade_en = 1'b1;
        press(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            frame();
        end
        total++; if (flag_sel !== 4'd2) begin bad++; $display("FAIL t5_fade_swap_flag got=%0d want=2", flag_sel); end
        tick();
        press(1'b0, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_fadein_busy got=%0b want=1", busy); end
        for (int k = 0; k < 8; k++) begin
            frame();
        end
        tick();
        tick();
        total++; if (flag_sel !== 4'd2) begin bad++; $display("FAIL t5_fadein_prev got=%0d want=2", flag_sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_fadein_done got=%0b want=0", busy); end
        total++; if (fade_level !== 3'd7) begin bad++; $display("FAIL t5_fadein_level got=%0d want=7", fade_level); end
        exp_flag = 4'd2;
    endtask

    task automatic test_dwell_zero();
        logic busy_seen;
        busy_seen = 1'b0;
        auto_en = 1'b1;
        dwell_frames = 8'd0;
        for (int i = 0; i < 100; i++) begin
            frame();
            busy_seen = busy_seen | busy;
            tick();
            busy_seen = busy_seen | busy;
        end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL t6_busy got=%0b want=0", busy_seen); end
        total++; if (flag_sel !== exp_flag) begin bad++; $display("FAIL t6_flag got=%0d want=%0d", flag_sel, exp_flag); end
        auto_en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        fade_en = 1'b1;
        press(1'b1, 1'b0);
        frame();
        frame();
        frame();
        total++; if (fade_level !== 3'd4) begin bad++; $display("FAIL t1_pre_level got=%0d want=4", fade_level); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_pre_busy got=%0b want=1", busy); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (flag_sel !== 4'd0) begin bad++; $display("FAIL t1_flag got=%0d want=0", flag_sel); end
        total++; if (fade_level !== 3'd7) begin bad++; $display("FAIL t1_level got=%0d want=7", fade_level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy got=%0b want=0", busy); end
        #1;
        rst = 1'b0;
        tick();
        frame();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_after_busy got=%0b want=0", busy); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_flag = 4'd0;
        rst = 1'b1;
        frame_start = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        auto_en = 1'b0;
        fade_en = 1'b0;
        dwell_frames = 8'd0;
        test_reset();
        test_manual_instant();
        test_wrap();
        test_auto_fade();
        test_collisions();
        test_dwell_zero();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
